// File: rtl/sig_gen_ctrl.sv
// Front-panel control for a signal generator: four raw keys are synchronized
// and debounced, press events drive the field/value state and run/stop, and
// all outputs are registered with a one-cycle cfg_upd notification.
module sig_gen_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PARAM_MAX       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_sel_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       key_run_n,
  output logic [4:0] state,
  output logic [7:0] state_freq,
  output logic [7:0] state_amp,
  output logic [7:0] state_phase,
  output logic [1:0] field,
  output logic       running,
  output logic       cfg_upd
);

  localparam int unsigned    NKEYS     = 4;
  localparam int unsigned    K_SEL     = 0;
  localparam int unsigned    K_UP      = 1;
  localparam int unsigned    K_DN      = 2;
  localparam int unsigned    K_RUN     = 3;
  localparam int unsigned    CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]     CODE_MAX  = 8'(PARAM_MAX);
  localparam logic [2:0]     WAVE_LAST = 3'd4;
  localparam logic [4:0]     STATE_OFF = 5'd10;

  typedef enum logic [1:0] {
    FLD_WAVE  = 2'd0,
    FLD_FREQ  = 2'd1,
    FLD_AMP   = 2'd2,
    FLD_PHASE = 2'd3
  } field_e;

  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] sync1_q;
  logic [NKEYS-1:0] sync2_q;
  logic [NKEYS-1:0] acc_q;
  logic [NKEYS-1:0] acc_d;
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] press_d;
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [CW-1:0]    cnt_d [NKEYS];

  field_e     field_q, field_d;
  logic [2:0] wave_q, wave_d;
  logic [7:0] freq_q, freq_d;
  logic [7:0] amp_q, amp_d;
  logic [7:0] phase_q, phase_d;
  logic       running_q, running_d;
  logic [4:0] state_q, state_d;
  logic       chg_q, chg_d;
  logic       cfg_upd_q, cfg_upd_d;

  logic sel_ev, up_ev, dn_ev, run_ev;

  assign key_raw = {key_run_n, key_dn_n, key_up_n, key_sel_n};

  // Saturating one-step move of a setting code within 0..CODE_MAX.
  function automatic logic [7:0] sat_step(input logic [7:0] v, input logic inc);
    logic [7:0] r;
    r = v;
    if (inc) begin
      if (v < CODE_MAX) r = v + 8'd1;
    end else begin
      if (v != 8'd0) r = v - 8'd1;
    end
    return r;
  endfunction

  // Per-key debounce: count while the synced level disagrees, accept on the last count.
  always_comb begin
    for (int unsigned i = 0; i < NKEYS; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          acc_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      press_d[i] = acc_q[i] & ~acc_d[i];
    end
  end

  // Synchronizer, debounce and press-event flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      acc_q   <= '1;
      press_q <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      press_q <= press_d;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sel_ev = press_q[K_SEL];
  assign up_ev  = press_q[K_UP];
  assign dn_ev  = press_q[K_DN];
  assign run_ev = press_q[K_RUN];

  // Event handling: sel > up > dn share one slot, run toggles independently.
  always_comb begin
    field_d   = field_q;
    wave_d    = wave_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    phase_d   = phase_q;
    running_d = running_q;

    if (sel_ev) begin
      case (field_q)
        FLD_WAVE:  field_d = FLD_FREQ;
        FLD_FREQ:  field_d = FLD_AMP;
        FLD_AMP:   field_d = FLD_PHASE;
        default:   field_d = FLD_WAVE;
      endcase
    end else if (up_ev || dn_ev) begin
      case (field_q)
        FLD_WAVE: begin
          if (up_ev) begin
            wave_d = (wave_q >= WAVE_LAST) ? 3'd0 : wave_q + 3'd1;
          end else begin
            wave_d = (wave_q == 3'd0) ? WAVE_LAST : wave_q - 3'd1;
          end
        end
        FLD_FREQ:  freq_d  = sat_step(freq_q, up_ev);
        FLD_AMP:   amp_d   = sat_step(amp_q, up_ev);
        default:   phase_d = sat_step(phase_q, up_ev);
      endcase
    end

    if (run_ev) begin
      running_d = ~running_q;
    end

    state_d = running_d ? {2'b00, wave_d} : STATE_OFF;

    // Change is flagged first and echoed on cfg_upd one cycle after the outputs move.
    chg_d = (state_d != state_q) || (freq_d != freq_q) ||
            (amp_d != amp_q) || (phase_d != phase_q);
    cfg_upd_d = chg_q;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q   <= FLD_WAVE;
      wave_q    <= '0;
      freq_q    <= '0;
      amp_q     <= '0;
      phase_q   <= '0;
      running_q <= 1'b1;
      state_q   <= '0;
      chg_q     <= 1'b0;
      cfg_upd_q <= 1'b0;
    end else begin
      field_q   <= field_d;
      wave_q    <= wave_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      phase_q   <= phase_d;
      running_q <= running_d;
      state_q   <= state_d;
      chg_q     <= chg_d;
      cfg_upd_q <= cfg_upd_d;
    end
  end

  assign state       = state_q;
  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign field       = field_q;
  assign running     = running_q;
  assign cfg_upd     = cfg_upd_q;

endmodule
